// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Default 640x480@60 raster timing shared by the timing generator and by the
//   sprite / pipe / background ROM interfaces that need the visible-area bounds.
//   Contents:
//     CNT_W              width of the raster counters (11 bits, totals <= 2048)
//     VGA_*              default porch / sync / visible sizes and clock divide
//     VGA_H_TOTAL/V_TOTAL  default scan totals (800 x 525)
//     sync_bits_t        packed {hs, vs, blank} bundle carried through the delay
//     SYNC_IDLE_BITS     inactive value of that bundle (hs=1, vs=1, blank=1)
//     div_width()        width needed for a 0..n-1 divider counter
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int CNT_W = 11;

    localparam int VGA_CLK_DIV    = 4;
    localparam int VGA_SYNC_DELAY = 1;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;

    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;

    localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Bit order matters: the top unpacks the delayed bundle as {hsync, vsync, blank}.
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } sync_bits_t;

    localparam logic [2:0] SYNC_IDLE_BITS = 3'b111;

    // A divide-by-1 still needs a one-bit counter so the port widths stay legal.
    function automatic int div_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// -----------------------------------------------------------------------------
// sync_delay_line
//   Enabled shift register used to retime the {hsync, vsync, blank} strobes so
//   they line up with the registered sprite ROM output.
//   Parameters:
//     WIDTH      bits per stage
//     DEPTH      number of stages; 0 makes q a straight wire from d
//     RESET_VAL  value loaded into every stage while rst_n is low
//   Ports:
//     clk    in   system clock
//     rst_n  in   synchronous reset, active low
//     en     in   shift strobe; stages hold when low
//     d      in   WIDTH-bit input sample
//     q      out  WIDTH-bit output, d as seen DEPTH enabled strobes earlier
// -----------------------------------------------------------------------------
module sync_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q = d;
        end else begin : g_shift
            // tap[i] is the input of stage i; tap[DEPTH] is the line output.
            logic [WIDTH-1:0] tap [DEPTH+1];

            assign tap[0] = d;

            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                logic [WIDTH-1:0] stage_q;
                logic [WIDTH-1:0] stage_d;

                always_comb begin
                    stage_d = stage_q;
                    if (en) begin
                        stage_d = tap[gi];
                    end
                end

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        stage_q <= RESET_VAL;
                    end else begin
                        stage_q <= stage_d;
                    end
                end

                assign tap[gi+1] = stage_q;
            end

            assign q = tap[DEPTH];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Raster scan generator. Divides clk down to a one-cycle pixel strobe, walks
//   the H_TOTAL x V_TOTAL raster, decodes sync/blank from the raster position
//   and retimes those strobes by SYNC_DELAY pixels so they match the 1-cycle
//   registered sprite ROM data consumed by the downstream colour mux.
//   Ports:
//     clk          in   system clock
//     rst_n        in   synchronous reset, active low
//     pixel_en     out  one-clk strobe every CLK_DIV clocks; counters step on it
//     hcounter     out  current column, 0..H_TOTAL-1
//     vcounter     out  current line,   0..V_TOTAL-1
//     hsync        out  horizontal sync, active low, delayed SYNC_DELAY pixels
//     vsync        out  vertical sync, active low, delayed SYNC_DELAY pixels
//     blank        out  high outside the visible area, delayed SYNC_DELAY pixels
//     frame_start  out  one-clk pulse when the raster wraps back to (0,0)
//   Constraints: CLK_DIV >= 1, SYNC_DELAY in 0..7, H_TOTAL and V_TOTAL <= 2048.
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV    = VGA_CLK_DIV,
    parameter int H_VISIBLE  = VGA_H_VISIBLE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_VISIBLE  = VGA_V_VISIBLE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter int SYNC_DELAY = VGA_SYNC_DELAY
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             pixel_en,
    output logic [CNT_W-1:0] hcounter,
    output logic [CNT_W-1:0] vcounter,
    output logic             hsync,
    output logic             vsync,
    output logic             blank,
    output logic             frame_start
);

    // ------------------------------------------------------------------
    // Raster boundaries, all resolved at elaboration time.
    // ------------------------------------------------------------------
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam int               DIV_W    = div_width(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             pixel_en_q;
    logic             pixel_en_d;
    logic [CNT_W-1:0] hcounter_q;
    logic [CNT_W-1:0] hcounter_d;
    logic [CNT_W-1:0] vcounter_q;
    logic [CNT_W-1:0] vcounter_d;
    logic             frame_start_q;
    logic             frame_start_d;

    logic             h_at_end;
    logic             v_at_end;
    sync_bits_t       raw_sync;
    logic [2:0]       delayed_sync;

    // ------------------------------------------------------------------
    // Pixel-rate divider. pixel_en is registered off the terminal count, so
    // it rises in the cycle after div reaches CLK_DIV-1. For CLK_DIV=1 the
    // terminal compare is always true and pixel_en stays high after reset.
    // ------------------------------------------------------------------
    always_comb begin
        div_d      = div_q + DIV_ONE;
        pixel_en_d = 1'b0;
        if (div_q == DIV_LAST) begin
            div_d      = '0;
            pixel_en_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Raster counters: step only on pixel_en, line advances on column wrap.
    // ------------------------------------------------------------------
    assign h_at_end = (hcounter_q == H_LAST);
    assign v_at_end = (vcounter_q == V_LAST);

    always_comb begin
        hcounter_d = hcounter_q;
        vcounter_d = vcounter_q;
        if (pixel_en_q) begin
            if (h_at_end) begin
                hcounter_d = '0;
                vcounter_d = v_at_end ? '0 : (vcounter_q + CNT_ONE);
            end else begin
                hcounter_d = hcounter_q + CNT_ONE;
            end
        end
    end

    // Registered alongside the counters so it is high in exactly the cycle
    // the raster first reads (0,0) after a full-frame wrap. The reset-time
    // (0,0) never sets it because no wrap step occurred.
    assign frame_start_d = pixel_en_q & h_at_end & v_at_end;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q         <= '0;
            pixel_en_q    <= 1'b0;
            hcounter_q    <= '0;
            vcounter_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            pixel_en_q    <= pixel_en_d;
            hcounter_q    <= hcounter_d;
            vcounter_q    <= vcounter_d;
            frame_start_q <= frame_start_d;
        end
    end

    // ------------------------------------------------------------------
    // Raw strobe decode from the current raster position.
    // ------------------------------------------------------------------
    always_comb begin
        raw_sync.hs    = ~((hcounter_q >= HS_START) && (hcounter_q < HS_END));
        raw_sync.vs    = ~((vcounter_q >= VS_START) && (vcounter_q < VS_END));
        raw_sync.blank = (hcounter_q >= H_VIS_END) || (vcounter_q >= V_VIS_END);
    end

    // ------------------------------------------------------------------
    // Retime the strobes. The line shifts on the same pixel_en that steps the
    // counters, so each stage captures the strobe of the position being left;
    // the output therefore describes the position SYNC_DELAY pixels back.
    // ------------------------------------------------------------------
    sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (SYNC_DELAY),
        .RESET_VAL (SYNC_IDLE_BITS)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pixel_en_q),
        .d     (raw_sync),
        .q     (delayed_sync)
    );

    assign pixel_en    = pixel_en_q;
    assign hcounter    = hcounter_q;
    assign vcounter    = vcounter_q;
    assign frame_start = frame_start_q;
    assign {hsync, vsync, blank} = delayed_sync;

endmodule
